// File: rtl/spi_flash_read_seq.sv
// Serial-flash READ sequencer: drives the SPI master core's register port to send
// opcode + 24-bit address, then streams the received data bytes out on valid/ready.
module spi_flash_read_seq #(
  parameter logic [7:0]  CMD_READ = 8'h03,
  parameter logic [15:0] SS_MASK  = 16'h0001,
  parameter int          LEN_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [23:0]      start_addr,
  input  logic [LEN_W-1:0] byte_count,
  output logic             busy,
  output logic             done,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic             spi_select,
  output logic [2:0]       mem_addr,
  output logic [15:0]      data_from_cpu,
  output logic             write_n,
  output logic             read_n,
  input  logic [15:0]      data_to_cpu
);

  typedef enum logic [3:0] {
    S_IDLE, S_SET_SS, S_SSO_ON, S_TX_WR, S_POLL_RRDY, S_RX_RD,
    S_PUSH, S_POLL_TMT, S_SSO_OFF, S_DONE
  } state_e;

  typedef struct packed {
    logic        sel;
    logic [2:0]  addr;
    logic        wr_n;
    logic        rd_n;
    logic [15:0] wdata;
  } bus_t;

  localparam bus_t BUS_IDLE = '{sel: 1'b0, addr: 3'd0, wr_n: 1'b1, rd_n: 1'b1, wdata: 16'h0000};

  // Register access that each bus state performs when it is entered.
  function automatic bus_t bus_for(input state_e s, input logic [7:0] tx);
    bus_t b;
    case (s)
      S_SET_SS:                b = '{1'b1, 3'd5, 1'b0, 1'b1, SS_MASK};
      S_SSO_ON:                b = '{1'b1, 3'd3, 1'b0, 1'b1, 16'h0400};
      S_TX_WR:                 b = '{1'b1, 3'd1, 1'b0, 1'b1, {8'h00, tx}};
      S_POLL_RRDY, S_POLL_TMT: b = '{1'b1, 3'd2, 1'b1, 1'b0, 16'h0000};
      S_RX_RD:                 b = '{1'b1, 3'd0, 1'b1, 1'b0, 16'h0000};
      S_SSO_OFF:               b = '{1'b1, 3'd3, 1'b0, 1'b1, 16'h0000};
      default:                 b = BUS_IDLE;
    endcase
    return b;
  endfunction

  function automatic logic [7:0] tx_byte(input logic [2:0] hdr, input logic [23:0] addr);
    case (hdr)
      3'd0:    return CMD_READ;
      3'd1:    return addr[23:16];
      3'd2:    return addr[15:8];
      3'd3:    return addr[7:0];
      default: return 8'h00;
    endcase
  endfunction

  state_e           state_q, state_d, nxt;
  logic [1:0]       ph_q, ph_d;
  bus_t             bus_q, bus_d;
  logic [7:0]       rx_q, rx_d;
  logic [2:0]       hdr_q, hdr_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [23:0]      addr_q, addr_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             rd_valid_q, rd_valid_d;
  logic [7:0]       rd_data_q, rd_data_d;
  logic             go, acc_end, in_bus;
  logic             unused_hi;

  assign unused_hi = ^data_to_cpu[15:8];

  always_comb begin
    // NOTE: every variable gets a default here so no path leaves one unassigned (no latches).
    state_d    = state_q;
    ph_d       = ph_q;
    bus_d      = bus_q;
    rx_d       = rx_q;
    hdr_d      = hdr_q;
    rem_d      = rem_q;
    addr_d     = addr_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    rd_valid_d = rd_valid_q;
    rd_data_d  = rd_data_q;
    go         = 1'b0;
    nxt        = S_IDLE;
    acc_end    = 1'b0;
    in_bus     = !(state_q inside {S_IDLE, S_PUSH, S_DONE});

    // Phase 0/1: strobes active; phase 2: idle gap, where the next step is decided.
    if (in_bus) begin
      case (ph_q)
        2'd0: ph_d = 2'd1;
        2'd1: begin
          ph_d       = 2'd2;
          bus_d.sel  = 1'b0;
          bus_d.wr_n = 1'b1;
          bus_d.rd_n = 1'b1;
          if (!bus_q.rd_n) rx_d = data_to_cpu[7:0];
        end
        default: acc_end = 1'b1;
      endcase
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          addr_d = start_addr;
          rem_d  = byte_count;
          hdr_d  = 3'd0;
          if (byte_count == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            go  = 1'b1;
            nxt = S_SET_SS;
          end
        end
      end
      S_SET_SS:    if (acc_end) begin go = 1'b1; nxt = S_SSO_ON; end
      S_SSO_ON:    if (acc_end) begin go = 1'b1; nxt = S_TX_WR; end
      S_TX_WR:     if (acc_end) begin go = 1'b1; nxt = S_POLL_RRDY; end
      S_POLL_RRDY: if (acc_end) begin go = 1'b1; nxt = rx_q[7] ? S_RX_RD : S_POLL_RRDY; end
      S_RX_RD: begin
        if (acc_end) begin
          if (hdr_q < 3'd4) begin
            hdr_d = hdr_q + 3'd1;
            go    = 1'b1;
            nxt   = S_TX_WR;
          end else begin
            state_d    = S_PUSH;
            rd_valid_d = 1'b1;
            rd_data_d  = rx_q;
          end
        end
      end
      // The next byte is only clocked out once the consumer has taken this one.
      S_PUSH: begin
        if (rd_ready) begin
          rd_valid_d = 1'b0;
          rem_d      = rem_q - LEN_W'(1);
          go         = 1'b1;
          nxt        = (rem_q == LEN_W'(1)) ? S_POLL_TMT : S_TX_WR;
        end
      end
      S_POLL_TMT:  if (acc_end) begin go = 1'b1; nxt = rx_q[5] ? S_SSO_OFF : S_POLL_TMT; end
      S_SSO_OFF: begin
        if (acc_end) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (go) begin
      state_d = nxt;
      ph_d    = 2'd0;
      bus_d   = bus_for(nxt, tx_byte(hdr_d, addr_d));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ph_q       <= 2'd0;
      bus_q      <= BUS_IDLE;
      rx_q       <= 8'h00;
      hdr_q      <= 3'd0;
      rem_q      <= '0;
      addr_q     <= 24'h0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= 8'h00;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge value of its _d input.
      state_q    <= state_d;
      ph_q       <= ph_d;
      bus_q      <= bus_d;
      rx_q       <= rx_d;
      hdr_q      <= hdr_d;
      rem_q      <= rem_d;
      addr_q     <= addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign rd_valid      = rd_valid_q;
  assign rd_data       = rd_data_q;
  assign spi_select    = bus_q.sel;
  assign mem_addr      = bus_q.addr;
  assign data_from_cpu = bus_q.wdata;
  assign write_n       = bus_q.wr_n;
  assign read_n        = bus_q.rd_n;

endmodule

// File: tb/tb_spi_flash_read_seq.sv
// Directed bench for spi_flash_read_seq: a small SPI-core register model, a bus
// protocol monitor and hand-computed expected byte sequences.
module tb_spi_flash_read_seq;
  localparam int LEN_W = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [23:0]      start_addr = 24'h0;
  logic [LEN_W-1:0] byte_count = '0;
  logic             rd_ready = 1'b0;
  logic             busy, done, rd_valid, spi_select, write_n, read_n;
  logic [7:0]       rd_data;
  logic [2:0]       mem_addr;
  logic [15:0]      data_from_cpu;
  logic [15:0]      data_to_cpu = 16'h0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  spi_flash_read_seq #(.CMD_READ(8'h03), .SS_MASK(16'h0001), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
    .byte_count(byte_count), .busy(busy), .done(done), .rd_data(rd_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .spi_select(spi_select),
    .mem_addr(mem_addr), .data_from_cpu(data_from_cpu), .write_n(write_n),
    .read_n(read_n), .data_to_cpu(data_to_cpu)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // SPI core register model: addr0 rxdata, addr1 txdata, addr2 status, addr3 control, addr5 slave select.
  logic [7:0]  miso_mem [0:7];
  logic        rrdy = 1'b0, tmt = 1'b1, sso = 1'b0;
  logic [7:0]  rxd = 8'h00;
  int          shift_cnt = 0, tx_idx = 0, acc_len = 0;
  logic [7:0]  mosi_q [$];
  logic [15:0] ctrl_q [$];
  logic [15:0] ss_q [$];

  always @(posedge clk) begin
    if (reset) begin
      rrdy <= 1'b0; tmt <= 1'b1; sso <= 1'b0; shift_cnt <= 0; acc_len <= 0; data_to_cpu <= 16'h0;
    end else begin
      if (shift_cnt > 0) begin
        shift_cnt <= shift_cnt - 1;
        if (shift_cnt == 1) begin rrdy <= 1'b1; tmt <= 1'b1; end
      end
      if (spi_select) begin
        acc_len <= acc_len + 1;
        if (!read_n) begin
          case (mem_addr)
            3'd0:    data_to_cpu <= {8'h00, rxd};
            3'd2:    data_to_cpu <= {8'h00, rrdy, 1'b1, tmt, 5'h00};
            default: data_to_cpu <= 16'h0;
          endcase
        end
        if (acc_len == 1) begin
          if (!write_n) begin
            case (mem_addr)
              3'd1: begin
                mosi_q.push_back(data_from_cpu[7:0]);
                check("ss_low_at_tx", sso, 1);
                rxd       <= (tx_idx < 4) ? 8'hFF : miso_mem[tx_idx-4];
                tx_idx    <= tx_idx + 1;
                tmt       <= 1'b0;
                shift_cnt <= 16;
              end
              3'd3: begin
                ctrl_q.push_back(data_from_cpu);
                if (data_from_cpu == 16'h0000) check("tmt_before_sso_off", tmt, 1);
                sso <= data_from_cpu[10];
                if (data_from_cpu[10]) tx_idx <= 0;
              end
              3'd5:    ss_q.push_back(data_from_cpu);
              default: ;
            endcase
          end else if (!read_n && mem_addr == 3'd0) begin
            rrdy <= 1'b0;
          end
        end
      end else begin
        acc_len <= 0;
      end
    end
  end

  // Bus protocol and stream monitor, sampled on the falling edge.
  int          run = 0, sel_cycles = 0, done_pulses = 0;
  logic [2:0]  a0;
  logic [15:0] d0;
  logic        w0, r0, stab;
  logic [7:0]  stream_q [$];

  always @(negedge clk) begin
    if (reset) begin
      run = 0;
    end else if (spi_select) begin
      if (run == 0) begin
        a0 = mem_addr; d0 = data_from_cpu; w0 = write_n; r0 = read_n;
        stab = (write_n != read_n);
      end else if (mem_addr !== a0 || data_from_cpu !== d0 || write_n !== w0 || read_n !== r0) begin
        stab = 1'b0;
      end
      run++;
      sel_cycles++;
    end else begin
      if (run != 0) begin
        check("access_len", run, 2);
        check("access_stable", stab, 1);
      end
      if (!write_n || !read_n) check("idle_strobe", {write_n, read_n}, 2'b11);
      run = 0;
    end
    if (!reset && done) done_pulses++;
    if (!reset && rd_valid && rd_ready) stream_q.push_back(rd_data);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [23:0] a, input int n);
    start_addr = a;
    byte_count = n[LEN_W-1:0];
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) check({tag, "_timeout"}, 0, 1);
    @(negedge clk);
    check({tag, "_idle_after_done"}, {busy, done}, 2'b00);
  endtask

  task automatic check_bytes(input string tag, input logic [7:0] got[$], input int base,
                             input logic [7:0] exp[$]);
    check({tag, "_len"}, got.size() - base, exp.size());
    foreach (exp[i]) if (base + i < got.size()) check(tag, got[base+i], exp[i]);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctl"}, {busy, done, rd_valid, spi_select, write_n, read_n}, 6'b000011);
    check({tag, "_data"}, {rd_data, mem_addr, data_from_cpu}, 27'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int mb, sb, cb, ssb, dp, sc, n;
    logic stable;
    logic [7:0] e[$];

    tick(); tick(); tick();
    @(negedge clk);
    check_reset_outputs("reset_state");
    tick();
    reset = 1'b0;
    tick();

    // Basic 2-byte read.
    miso_mem[0] = 8'hA5; miso_mem[1] = 8'h3C;
    rd_ready = 1'b1;
    mb = mosi_q.size(); sb = stream_q.size(); cb = ctrl_q.size(); ssb = ss_q.size(); dp = done_pulses;
    launch(24'h123456, 2);
    wait_done("t1", 3000);
    tick();
    e = '{8'h03, 8'h12, 8'h34, 8'h56, 8'h00, 8'h00};
    check_bytes("t1_mosi", mosi_q, mb, e);
    e = '{8'hA5, 8'h3C};
    check_bytes("t1_stream", stream_q, sb, e);
    check("t1_ctrl_len", ctrl_q.size() - cb, 2);
    if (ctrl_q.size() - cb >= 2) begin
      check("t1_sso_on", ctrl_q[cb], 16'h0400);
      check("t1_sso_off", ctrl_q[cb+1], 16'h0000);
    end
    check("t1_ss_len", ss_q.size() - ssb, 1);
    if (ss_q.size() > ssb) check("t1_ss_mask", ss_q[ssb], 16'h0001);
    check("t1_done_pulses", done_pulses - dp, 1);

    // Zero-length request: done the next cycle, no bus activity.
    sc = sel_cycles; dp = done_pulses;
    tick();
    launch(24'h777777, 0);
    @(negedge clk);
    check("t2_done_hi", done, 1);
    check("t2_busy_hi", busy, 1);
    @(negedge clk);
    check("t2_done_lo", done, 0);
    check("t2_busy_lo", busy, 0);
    tick(); tick();
    check("t2_no_select", sel_cycles - sc, 0);
    check("t2_done_pulses", done_pulses - dp, 1);

    // Backpressure: consumer stalls 1000 cycles on the first data byte.
    miso_mem[0] = 8'h11; miso_mem[1] = 8'h22; miso_mem[2] = 8'h33;
    rd_ready = 1'b0;
    mb = mosi_q.size(); sb = stream_q.size();
    launch(24'hABCDEF, 3);
    n = 0;
    while (rd_valid !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
    if (n >= 3000) check("t3_valid_timeout", 0, 1);
    check("t3_first_byte", rd_data, 8'h11);
    check("t3_tx_before_stall", mosi_q.size() - mb, 5);
    stable = 1'b1;
    repeat (1000) begin
      @(negedge clk);
      if (rd_valid !== 1'b1 || rd_data !== 8'h11) stable = 1'b0;
    end
    check("t3_hold_stable", stable, 1);
    check("t3_no_tx_in_stall", mosi_q.size() - mb, 5);
    tick();
    rd_ready = 1'b1;
    wait_done("t3", 3000);
    tick();
    e = '{8'h03, 8'hAB, 8'hCD, 8'hEF, 8'h00, 8'h00, 8'h00};
    check_bytes("t3_mosi", mosi_q, mb, e);
    e = '{8'h11, 8'h22, 8'h33};
    check_bytes("t3_stream", stream_q, sb, e);

    // A second start while busy is dropped.
    miso_mem[0] = 8'h5A;
    mb = mosi_q.size(); sb = stream_q.size(); dp = done_pulses;
    launch(24'hFEDCBA, 1);
    repeat (10) tick();
    check("t4_busy", busy, 1);
    launch(24'h000000, 5);
    wait_done("t4", 3000);
    sc = sel_cycles;
    repeat (200) tick();
    e = '{8'h03, 8'hFE, 8'hDC, 8'hBA, 8'h00};
    check_bytes("t4_mosi", mosi_q, mb, e);
    e = '{8'h5A};
    check_bytes("t4_stream", stream_q, sb, e);
    check("t4_done_pulses", done_pulses - dp, 1);
    check("t4_no_second_txn", sel_cycles - sc, 0);

    // Reset while the second data byte is in flight, then a clean transaction.
    miso_mem[0] = 8'h01; miso_mem[1] = 8'h02; miso_mem[2] = 8'h03; miso_mem[3] = 8'h04;
    sb = stream_q.size();
    launch(24'h000100, 4);
    n = 0;
    while (stream_q.size() == sb && n < 3000) begin tick(); n++; end
    if (n >= 3000) check("t5_first_timeout", 0, 1);
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    @(negedge clk);
    check_reset_outputs("t5_mid_reset");
    tick();
    reset = 1'b0;
    check("t5_stream_cut", stream_q.size() - sb, 1);
    tick();
    miso_mem[0] = 8'hC1; miso_mem[1] = 8'hC2;
    mb = mosi_q.size(); sb = stream_q.size(); dp = done_pulses;
    launch(24'h000010, 2);
    wait_done("t5", 3000);
    tick();
    e = '{8'h03, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00};
    check_bytes("t5_mosi", mosi_q, mb, e);
    e = '{8'hC1, 8'hC2};
    check_bytes("t5_stream", stream_q, sb, e);
    check("t5_done_pulses", done_pulses - dp, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
